// File: rtl/ucsbece154b_branch_predictor_if.sv
// Fetch-lookup and execute-resolve signal bundle between the core and the branch predictor.
// The core side uses the master modport and the predictor uses the slave modport.
interface ucsbece154b_branch_predictor_if #(
  parameter int NUM_GHR_BITS = 5
);
  logic [31:0]             PCF_i;
  logic                    StallF_i;
  logic                    BranchTakenF_o;
  logic [31:0]             BranchTargetF_o;
  logic [NUM_GHR_BITS-1:0] GHRF_o;
  logic                    UpdateValidE_i;
  logic                    UpdateIsJumpE_i;
  logic                    UpdateTakenE_i;
  logic [31:0]             UpdatePCE_i;
  logic [31:0]             UpdateTargetE_i;
  logic [NUM_GHR_BITS-1:0] UpdateGHRE_i;
  logic                    MispredictE_i;

  modport master (
    output PCF_i, StallF_i, UpdateValidE_i, UpdateIsJumpE_i, UpdateTakenE_i,
           UpdatePCE_i, UpdateTargetE_i, UpdateGHRE_i, MispredictE_i,
    input  BranchTakenF_o, BranchTargetF_o, GHRF_o
  );

  modport slave (
    input  PCF_i, StallF_i, UpdateValidE_i, UpdateIsJumpE_i, UpdateTakenE_i,
           UpdatePCE_i, UpdateTargetE_i, UpdateGHRE_i, MispredictE_i,
    output BranchTakenF_o, BranchTargetF_o, GHRF_o
  );
endinterface

// File: rtl/ucsbece154b_branch_predictor.sv
// BTB plus direction predictor: combinational fetch lookup, resolve-time BTB/PHT/GHR update.
// Define BP_GSHARE_EN for gshare indexing (PC xor GHR); otherwise the predictor is bimodal.
module ucsbece154b_branch_predictor #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  ucsbece154b_branch_predictor_if.slave  bp
);
  localparam int IDXW  = $clog2(NUM_BTB_ENTRIES);
  localparam int TAGW  = 32 - IDXW - 2;
  localparam int PHT_N = 1 << NUM_GHR_BITS;

  logic                    btb_valid_r  [NUM_BTB_ENTRIES];
  logic [TAGW-1:0]         btb_tag_r    [NUM_BTB_ENTRIES];
  logic [31:0]             btb_target_r [NUM_BTB_ENTRIES];
  logic                    btb_jump_r   [NUM_BTB_ENTRIES];
  logic [1:0]              pht_r        [PHT_N];

  logic [IDXW-1:0]         bidx_s;
  logic [IDXW-1:0]         ubidx_s;
  logic [NUM_GHR_BITS-1:0] pidx_s;
  logic [NUM_GHR_BITS-1:0] upidx_s;
  logic [NUM_GHR_BITS-1:0] ghr_s;
  logic                    hit_s;
  logic                    pred_dir_s;
  logic [1:0]              pht_cur_s;
  logic [1:0]              pht_upd_s;
  logic                    unused_bits_s;

  assign bidx_s     = bp.PCF_i[IDXW+1:2];
  assign ubidx_s    = bp.UpdatePCE_i[IDXW+1:2];
  assign hit_s      = btb_valid_r[bidx_s] && (btb_tag_r[bidx_s] == bp.PCF_i[31:IDXW+2]);
  assign pred_dir_s = pht_r[pidx_s][1];

`ifdef BP_GSHARE_EN
  logic [NUM_GHR_BITS-1:0] ghr_r;
  logic [NUM_GHR_BITS-1:0] ghr_next_s;

  assign ghr_s   = ghr_r;
  assign pidx_s  = bp.PCF_i[NUM_GHR_BITS+1:2] ^ ghr_r;
  assign upidx_s = bp.UpdatePCE_i[NUM_GHR_BITS+1:2] ^ bp.UpdateGHRE_i;
  assign unused_bits_s = ^{bp.PCF_i[1:0], bp.UpdatePCE_i[1:0]};

  // Recovery from a resolved mispredict overrides the speculative fetch-side shift.
  always_comb begin
    ghr_next_s = ghr_r;
    if (bp.UpdateValidE_i && bp.MispredictE_i) begin
      if (bp.UpdateIsJumpE_i) begin
        ghr_next_s = bp.UpdateGHRE_i;
      end else begin
        ghr_next_s = {bp.UpdateGHRE_i[NUM_GHR_BITS-2:0], bp.UpdateTakenE_i};
      end
    end else if (!bp.StallF_i && hit_s && !btb_jump_r[bidx_s]) begin
      ghr_next_s = {ghr_r[NUM_GHR_BITS-2:0], pred_dir_s};
    end else begin
      ghr_next_s = ghr_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_r <= '0;
    end else begin
      ghr_r <= ghr_next_s;
    end
  end
`else
  assign ghr_s   = '0;
  assign pidx_s  = bp.PCF_i[NUM_GHR_BITS+1:2];
  assign upidx_s = bp.UpdatePCE_i[NUM_GHR_BITS+1:2];
  assign unused_bits_s = ^{bp.PCF_i[1:0], bp.UpdatePCE_i[1:0], bp.StallF_i,
                           bp.MispredictE_i, bp.UpdateGHRE_i};
`endif

  // Outputs are forced quiet while reset is held, before the state has been cleared.
  always_comb begin
    bp.BranchTargetF_o = btb_target_r[bidx_s];
    if (reset) begin
      bp.BranchTakenF_o = 1'b0;
      bp.GHRF_o         = '0;
    end else begin
      bp.BranchTakenF_o = hit_s && (btb_jump_r[bidx_s] || pred_dir_s);
      bp.GHRF_o         = ghr_s;
    end
  end

  // Saturating 2-bit counter step for the resolved branch.
  always_comb begin
    pht_cur_s = pht_r[upidx_s];
    pht_upd_s = pht_cur_s;
    if (bp.UpdateTakenE_i) begin
      if (pht_cur_s != 2'b11) pht_upd_s = pht_cur_s + 2'b01;
      else                    pht_upd_s = pht_cur_s;
    end else begin
      if (pht_cur_s != 2'b00) pht_upd_s = pht_cur_s - 2'b01;
      else                    pht_upd_s = pht_cur_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) btb_valid_r[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht_r[i] <= 2'b01;
    end else begin
      if (bp.UpdateValidE_i) btb_valid_r[ubidx_s] <= 1'b1;
      if (bp.UpdateValidE_i && !bp.UpdateIsJumpE_i) pht_r[upidx_s] <= pht_upd_s;
    end
  end

  // BTB payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (!reset && bp.UpdateValidE_i) begin
      btb_tag_r[ubidx_s]    <= bp.UpdatePCE_i[31:IDXW+2];
      btb_target_r[ubidx_s] <= bp.UpdateTargetE_i;
      btb_jump_r[ubidx_s]   <= bp.UpdateIsJumpE_i;
    end
  end
endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Directed-vector scoreboard bench for ucsbece154b_branch_predictor.
// Expected GHR values follow the BP_GSHARE_EN build setting.
module tb_ucsbece154b_branch_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ucsbece154b_branch_predictor_if #(.NUM_GHR_BITS(5)) bp_if ();
  ucsbece154b_branch_predictor #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk(clk), .reset(reset), .bp(bp_if)
  );

  typedef struct {
    bit rst; logic [31:0] pc; bit st;
    bit uv; bit uj; bit ut; logic [31:0] upc; logic [31:0] utgt; logic [4:0] ughr; bit um;
    bit ct; bit et; bit cg; logic [31:0] etgt; logic [4:0] eghr;
  } row_t;

  typedef struct {
    int idx; bit ct; bit et; bit cg; logic [31:0] etgt; logic [4:0] eghr;
  } exp_t;

  row_t rows[$];
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic add(bit rst, logic [31:0] pc, bit st, bit uv, bit uj, bit ut,
                     logic [31:0] upc, logic [31:0] utgt, logic [4:0] ughr, bit um,
                     bit ct, bit et, bit cg, logic [31:0] etgt, logic [4:0] eghr_gs);
    row_t r;
    r.rst = rst; r.pc = pc; r.st = st; r.uv = uv; r.uj = uj; r.ut = ut;
    r.upc = upc; r.utgt = utgt; r.ughr = ughr; r.um = um;
    r.ct = ct; r.et = et; r.cg = cg; r.etgt = etgt;
`ifdef BP_GSHARE_EN
    r.eghr = eghr_gs;
`else
    r.eghr = 5'd0;
`endif
    rows.push_back(r);
  endtask

  // Monitor: outputs are combinational, so every driven row is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.ct) begin
        checks++;
        if (bp_if.BranchTakenF_o !== e.et) begin
          failures++;
          $display("FAIL row%0d taken: got %0b want %0b", e.idx, bp_if.BranchTakenF_o, e.et);
        end
      end
      if (e.cg) begin
        checks++;
        if (bp_if.BranchTargetF_o !== e.etgt) begin
          failures++;
          $display("FAIL row%0d target: got %h want %h", e.idx, bp_if.BranchTargetF_o, e.etgt);
        end
      end
      checks++;
      if (bp_if.GHRF_o !== e.eghr) begin
        failures++;
        $display("FAIL row%0d ghr: got %b want %b", e.idx, bp_if.GHRF_o, e.eghr);
      end
    end
  end

  initial begin
    bp_if.PCF_i = 32'h0; bp_if.StallF_i = 1'b1;
    bp_if.UpdateValidE_i = 1'b0; bp_if.UpdateIsJumpE_i = 1'b0; bp_if.UpdateTakenE_i = 1'b0;
    bp_if.UpdatePCE_i = 32'h0; bp_if.UpdateTargetE_i = 32'h0;
    bp_if.UpdateGHRE_i = 5'd0; bp_if.MispredictE_i = 1'b0;

    //   rst pc        st uv uj ut upc       utgt       ughr   um ct et cg etgt       eghr(gshare)
    add(1, 32'h10, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(1, 32'h10, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h10, 1, 1, 1, 1, 32'h10, 32'h040, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h10, 0, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h40,  5'd0);
    add(0, 32'h10, 0, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h40,  5'd0);
    // Branch at 0x20: counter walks 01->10->11 (sat) ->10->01->00 (sat) ->01->10->11.
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 32'h008, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 32'h008, 5'd0,  0, 1, 1, 1, 32'h08,  5'd0);
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 32'h008, 5'd0,  0, 1, 1, 1, 32'h08,  5'd0);
    add(0, 32'h20, 1, 1, 0, 0, 32'h20, 32'h008, 5'd0,  0, 1, 1, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 0, 32'h20, 32'h008, 5'd0,  0, 1, 1, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 0, 32'h20, 32'h008, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 0, 32'h20, 32'h008, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 32'h008, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 32'h008, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 1, 32'h20, 32'h008, 5'd0,  0, 1, 1, 0, 32'h00,  5'd0);
    // Speculative shift: stalled, then unstalled.
    add(0, 32'h20, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h08,  5'd0);
    add(0, 32'h20, 0, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h08,  5'd0);
    add(0, 32'h10, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h40,  5'd1);
    // Branch recovery racing a speculative shift, then jump recovery.
    add(0, 32'h20, 0, 1, 0, 0, 32'h30, 32'h100, 5'd6,  1, 0, 0, 0, 32'h00,  5'd1);
    add(0, 32'h10, 1, 1, 1, 1, 32'h50, 32'h200, 5'd3,  1, 1, 1, 1, 32'h40,  5'd12);
    add(0, 32'h50, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h200, 5'd3);
    // 0x90 aliases 0x10 and evicts it.
    add(0, 32'h10, 1, 1, 1, 1, 32'h90, 32'h300, 5'd0,  0, 1, 1, 1, 32'h40,  5'd3);
    add(0, 32'h10, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 0, 0, 32'h00,  5'd3);
    add(0, 32'h90, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h300, 5'd3);
    // Mispredict without UpdateValidE_i must not touch the GHR.
    add(0, 32'h90, 1, 0, 0, 0, 32'h00, 32'h000, 5'd31, 1, 1, 1, 1, 32'h300, 5'd3);
    add(0, 32'h90, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 1, 1, 32'h300, 5'd3);
    // Mid-run reset: learned state dropped, update during reset ignored, PHT back to 01.
    add(1, 32'h90, 1, 1, 1, 1, 32'h10, 32'h040, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h90, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h10, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 1, 0, 0, 32'h20, 32'h008, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);
    add(0, 32'h20, 1, 0, 0, 0, 32'h00, 32'h000, 5'd0,  0, 1, 0, 0, 32'h00,  5'd0);

    for (int i = 0; i < rows.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      reset                 = rows[i].rst;
      bp_if.PCF_i           = rows[i].pc;
      bp_if.StallF_i        = rows[i].st;
      bp_if.UpdateValidE_i  = rows[i].uv;
      bp_if.UpdateIsJumpE_i = rows[i].uj;
      bp_if.UpdateTakenE_i  = rows[i].ut;
      bp_if.UpdatePCE_i     = rows[i].upc;
      bp_if.UpdateTargetE_i = rows[i].utgt;
      bp_if.UpdateGHRE_i    = rows[i].ughr;
      bp_if.MispredictE_i   = rows[i].um;
      e.idx = i; e.ct = rows[i].ct; e.et = rows[i].et; e.cg = rows[i].cg;
      e.etgt = rows[i].etgt; e.eghr = rows[i].eghr;
      exp_q.push_back(e);
    end

    @(posedge clk);
    #1;
    bp_if.UpdateValidE_i = 1'b0;
    bp_if.MispredictE_i  = 1'b0;
    bp_if.StallF_i       = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
